modbus_frame_tx: RTL and testbench
==================================

# modbus_frame_tx

Modbus RTU frame transmitter: fetches a frame's bytes from a host buffer, appends the CRC16, and drives `uart_byte_tx` one byte at a time. It enforces at least 3.5 character times of line silence before each frame and keeps inter-byte gaps well below 1.5 character times. It is the transmit counterpart of the receive-side frame delimiter `ct_35t_gen`, and sits between the slave's response builder and `uart_byte_tx`.

## Interface
- `CLK_FREQ`, default 50000000: system clock in Hz.
- `BAUD_RATE`, default 115200: UART baud rate.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `send_req`  in  1  single-cycle pulse that starts a frame.
- `send_len`  in  8  payload byte count, excluding CRC; sampled when `send_req` is accepted; legal range 1..255.
- `byte_rd`  out  1  single-cycle request for payload byte `byte_idx`.
- `byte_idx`  out  8  index of the requested byte, 0-based.
- `byte_data`  in  8  host data, sampled exactly 1 cycle after `byte_rd`.
- `busy`  out  1  high from accepting `send_req` until `send_done`.
- `send_done`  out  1  single-cycle pulse after the last byte's `tx_done`.
- `tx_start`  out  1  single-cycle start pulse to `uart_byte_tx`.
- `tx_data`  out  8  byte to `uart_byte_tx`; held stable from `tx_start` until `tx_done`.
- `tx_done`  in  1  byte-complete pulse from `uart_byte_tx`.

## Operation
- `T35_CYCLES` is fixed by baud rate:
  - If `BAUD_RATE > 19200`: `(CLK_FREQ/1000000)*1750` (fixed 1750 µs; 87500 cycles at defaults).
  - Otherwise: `(CLK_FREQ/BAUD_RATE)*35`.
- Silence counter:
  - Cleared by `tx_done` and by reset.
  - Otherwise increments, saturating at `T35_CYCLES`.
  - Width is `$clog2(T35_CYCLES+1)`.
- States:
  - IDLE: `send_req` with `send_len != 0` latches the length, clears the CRC and goes to GAP. `send_req` with `send_len == 0` is ignored: no `busy`, no `send_done`.
  - GAP: waits until the silence counter equals `T35_CYCLES`, then goes to FETCH.
  - FETCH: pulses `byte_rd` with the current `byte_idx`, then goes to LOAD.
  - LOAD: captures `byte_data` into `tx_data`, pulses `tx_start`, feeds the byte to the CRC, then goes to WAIT.
  - WAIT: on `tx_done`, increments the index. If more payload remains, go to FETCH; else go to CRC_LO (macro defined) or DONE.
  - CRC_LO: sends `crc[7:0]`, waits for `tx_done`, then goes to CRC_HI.
  - CRC_HI: sends `crc[15:8]`, waits for `tx_done`, then goes to DONE.
  - DONE: pulses `send_done`, deasserts `busy`, returns to IDLE.
- `send_req` while `busy` is ignored and has no effect on the frame in flight.
- CRC is Modbus CRC16: reflected polynomial 0xA001, init 0xFFFF, low byte transmitted first. It is computed bit-serially, 8 cycles per byte, and finishes long before that byte's `tx_done`.
- A `tx_done` outside WAIT/CRC states is ignored, but still clears the silence counter.

## Timing
- Reset values: `tx_start`=0, `tx_data`=0, `byte_rd`=0, `byte_idx`=0, `busy`=0, `send_done`=0, state IDLE, silence counter 0.
- Because the counter resets to 0, the first frame after reset waits the full `T35_CYCLES`.
- From `send_req` to first `tx_start`: max(2, remaining silence + 2) cycles.
- From `tx_done` to the next byte's `tx_start`: exactly 2 cycles for payload bytes (FETCH, LOAD) and 1 cycle for CRC bytes.
- `send_done` occurs 1 cycle after the final `tx_done`.
- A back-to-back `send_req` after `send_done` waits out the full 3.5T from the last `tx_done`.
- `rst_n` low mid-frame aborts immediately: no `send_done`, counter 0, so the next frame waits the full 3.5T.

## Configuration
- `MODBUS_TX_CRC_EN` defined: the CRC sub-module is instantiated and 2 CRC bytes are appended; frame length is `send_len+2`.
- Not defined: no CRC logic; exactly `send_len` bytes are sent, and the host supplies the CRC inside the payload. WAIT goes directly to DONE.

## Structure
- Package `modbus_rtu_pkg` holds:
  - state encoding (one-hot, 9 states);
  - `CRC16_POLY` = 16'hA001, `CRC16_INIT` = 16'hFFFF;
  - `T35_FIXED_US` = 1750;
  - `T35_BAUD_LIMIT` = 19200.
- One sub-module, `modbus_crc16`:
  - inputs: `clk`, `rst_n`, `crc_clr`, `crc_en`, `crc_din[7:0]`;
  - outputs: `crc[15:0]`, `crc_busy`.
  - Bit-serial, 8 cycles per byte.

## Test plan
- `send_req`, `send_len`=6, payload 01 03 00 00 00 0A, macro on -> UART line carries 01 03 00 00 00 0A C5 CD; one `send_done`.
- Same frame with the macro off -> exactly 6 bytes on the line, no C5 CD.
- `send_req` 10 cycles after reset -> first `tx_start` at or after cycle `T35_CYCLES`; `ct_35t_gen` flags a new frame.
- Two frames back-to-back -> gap between the last `tx_done` of frame 1 and the first `tx_start` of frame 2 is at least 87500 cycles; inter-byte gap within each frame is 2 cycles.
- `send_req` while `busy`, and `send_req` with `send_len`=0 -> ignored; no extra bytes, no extra `send_done`.
- `rst_n` low for 1 cycle during byte 3 -> outputs at reset values next cycle; no `send_done`; a new request waits the full 3.5T.

Source files
------------

// File: rtl/modbus_rtu_pkg.sv
// Shared definitions for the Modbus RTU transmit path: FSM encoding, CRC16
// constants, 3.5-character silence timing and a single-bit CRC step helper.
package modbus_rtu_pkg;

    typedef enum logic [8:0] {
        ST_IDLE     = 9'b0_0000_0001,
        ST_GAP      = 9'b0_0000_0010,
        ST_FETCH    = 9'b0_0000_0100,
        ST_LOAD     = 9'b0_0000_1000,
        ST_WAIT     = 9'b0_0001_0000,
        ST_CRC_LO   = 9'b0_0010_0000,
        ST_CRC_HI   = 9'b0_0100_0000,
        ST_CRC_WAIT = 9'b0_1000_0000,
        ST_DONE     = 9'b1_0000_0000
    } state_e;

    localparam logic [15:0] CRC16_POLY = 16'hA001;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    localparam int T35_FIXED_US   = 1750;
    localparam int T35_BAUD_LIMIT = 19200;
    // 3.5 characters of 10 bits each, expressed in bit times.
    localparam int T35_BIT_TIMES  = 35;

    function automatic int t35_cycles(input int clk_freq, input int baud_rate);
        if (baud_rate > T35_BAUD_LIMIT) begin
            return (clk_freq / 1_000_000) * T35_FIXED_US;
        end
        return (clk_freq / baud_rate) * T35_BIT_TIMES;
    endfunction

    function automatic logic [15:0] crc16_shift(input logic [15:0] c);
        return c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
    endfunction

endpackage

// File: rtl/modbus_crc16.sv
// Bit-serial Modbus CRC16 (reflected 0xA001, init 0xFFFF): one byte is folded
// in over 8 clock cycles, crc_busy high while the shift is in progress.
module modbus_crc16
    import modbus_rtu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        crc_clr,
    input  logic        crc_en,
    input  logic [7:0]  crc_din,
    output logic [15:0] crc,
    output logic        crc_busy
);

    logic [15:0] crc_q, crc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        run_q, run_d;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        crc_d = crc_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (crc_clr) begin
            crc_d = CRC16_INIT;
            cnt_d = 3'd0;
            run_d = 1'b0;
        end else if (crc_en) begin
            // The XOR-in shares a cycle with the first shift: 8 cycles per byte.
            crc_d = crc16_shift(crc_q ^ {8'h00, crc_din});
            cnt_d = 3'd7;
            run_d = 1'b1;
        end else if (run_q) begin
            crc_d = crc16_shift(crc_q);
            cnt_d = cnt_q - 3'd1;
            run_d = (cnt_q != 3'd1);
        end
    end

    // NOTE: the reset is synchronous (sampled on the clock edge), and state is
    // updated with non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q <= CRC16_INIT;
            cnt_q <= 3'd0;
            run_q <= 1'b0;
        end else begin
            crc_q <= crc_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign crc      = crc_q;
    assign crc_busy = run_q;

endmodule

// File: rtl/modbus_frame_tx.sv
// Modbus RTU frame transmitter: guards 3.5T line silence, fetches payload bytes
// from the host and drives uart_byte_tx; MODBUS_TX_CRC_EN appends the CRC16.
module modbus_frame_tx
    import modbus_rtu_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_req,
    input  logic [7:0] send_len,
    output logic       byte_rd,
    output logic [7:0] byte_idx,
    input  logic [7:0] byte_data,
    output logic       busy,
    output logic       send_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done
);

    localparam int T35_CYCLES = t35_cycles(CLK_FREQ, BAUD_RATE);
    localparam int SIL_W      = $clog2(T35_CYCLES + 1);
    localparam logic [SIL_W-1:0] SIL_MAX = SIL_W'(T35_CYCLES);

    state_e           state_q, state_d;
    logic [SIL_W-1:0] sil_q, sil_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       idx_q, idx_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       send_byte;
    logic             accept;
    logic             last_byte;

    assign accept    = (state_q == ST_IDLE) && send_req && (send_len != 8'd0);
    assign last_byte = ({1'b0, idx_q} + 9'd1) >= {1'b0, len_q};

`ifdef MODBUS_TX_CRC_EN
    logic [15:0] crc_val;
    logic        crc_busy;
    logic        crc_hi_q, crc_hi_d;

    modbus_crc16 u_crc (
        .clk      (clk),
        .rst_n    (rst_n),
        .crc_clr  (accept),
        .crc_en   (state_q == ST_LOAD),
        .crc_din  (byte_data),
        .crc      (crc_val),
        .crc_busy (crc_busy)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_GAP;
            ST_GAP:   if (sil_q == SIL_MAX) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (tx_done) begin
`ifdef MODBUS_TX_CRC_EN
                    state_d = last_byte ? ST_CRC_LO : ST_FETCH;
`else
                    state_d = last_byte ? ST_DONE : ST_FETCH;
`endif
                end
            end
`ifdef MODBUS_TX_CRC_EN
            // Hold the low CRC byte until the serial update has settled.
            ST_CRC_LO:   if (!crc_busy) state_d = ST_CRC_WAIT;
            ST_CRC_HI:   state_d = ST_CRC_WAIT;
            ST_CRC_WAIT: if (tx_done) state_d = crc_hi_q ? ST_DONE : ST_CRC_HI;
`endif
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_rd   = 1'b0;
        tx_start  = 1'b0;
        send_done = 1'b0;
        send_byte = byte_data;
        case (state_q)
            ST_FETCH: byte_rd = 1'b1;
            ST_LOAD:  tx_start = 1'b1;
`ifdef MODBUS_TX_CRC_EN
            ST_CRC_LO: begin
                tx_start  = !crc_busy;
                send_byte = crc_val[7:0];
            end
            ST_CRC_HI: begin
                tx_start  = 1'b1;
                send_byte = crc_val[15:8];
            end
`endif
            ST_DONE:  send_done = 1'b1;
            default:  ;
        endcase
    end

    assign busy     = !(state_q inside {ST_IDLE, ST_DONE});
    assign byte_idx = idx_q;
    // The byte is presented in the tx_start cycle and held from the register after.
    assign tx_data  = tx_start ? send_byte : tx_data_q;

    always_comb begin
        sil_d     = sil_q;
        len_d     = len_q;
        idx_d     = idx_q;
        tx_data_d = tx_data;
        if (tx_done) begin
            sil_d = '0;
        end else if (sil_q != SIL_MAX) begin
            sil_d = sil_q + SIL_W'(1);
        end
        if (accept) begin
            len_d = send_len;
            idx_d = 8'd0;
        end else if ((state_q == ST_WAIT) && tx_done) begin
            idx_d = idx_q + 8'd1;
        end
    end

`ifdef MODBUS_TX_CRC_EN
    always_comb begin
        crc_hi_d = crc_hi_q;
        if (accept) begin
            crc_hi_d = 1'b0;
        end else if (state_q == ST_CRC_HI) begin
            crc_hi_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_hi_q <= 1'b0;
        end else begin
            crc_hi_q <= crc_hi_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sil_q     <= '0;
            len_q     <= 8'd0;
            idx_q     <= 8'd0;
            tx_data_q <= 8'd0;
        end else begin
            sil_q     <= sil_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            tx_data_q <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_modbus_frame_tx.sv
// Scoreboard bench for modbus_frame_tx: a UART/host model on the falling edge
// pops expected bytes and gap windows pushed by the directed stimulus.
module tb_modbus_frame_tx;

    localparam int CLK_FREQ  = 100_000;
    localparam int BAUD_RATE = 9600;
    localparam int T35       = (100_000 / 9600) * 35;  // 10 cycles/bit * 35 = 350
    localparam int UART_CYC  = 16;
    localparam int WAIT_MAX  = 3000;
`ifdef MODBUS_TX_CRC_EN
    localparam int FRAME_BYTES = 8;
`else
    localparam int FRAME_BYTES = 6;
`endif

    typedef struct {
        logic [7:0] data;
        int         gmin;
        int         gmax;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       send_req = 1'b0;
    logic [7:0] send_len = 8'd0;
    logic       byte_rd;
    logic [7:0] byte_idx;
    logic [7:0] byte_data = 8'd0;
    logic       busy;
    logic       send_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done = 1'b0;

    logic [7:0] mem [256];
    exp_t       exp_q [$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         rst_ref = 0;
    int         cnt = 0;
    int         done_cnt = 0;
    int         starts_cnt = 0;
    int         last_done = 0;
    logic [7:0] cur_exp = 8'd0;
    logic       have_exp = 1'b0;

    always #5 clk = ~clk;

    modbus_frame_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .send_req  (send_req),
        .send_len  (send_len),
        .byte_rd   (byte_rd),
        .byte_idx  (byte_idx),
        .byte_data (byte_data),
        .busy      (busy),
        .send_done (send_done),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_done   (tx_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // Cycle index; rst_ref marks the last edge that saw reset asserted.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) rst_ref = cyc;
    end

    // UART, host buffer and output monitor, all sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            cnt      = 0;
            tx_done  = 1'b0;
            have_exp = 1'b0;
        end else begin
            if (send_done) done_cnt++;
            if (tx_done) tx_done = 1'b0;
            if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    if (have_exp) check("tx_data held until tx_done", tx_data, cur_exp);
                    tx_done   = 1'b1;
                    last_done = cyc;
                end
            end else if (tx_start) begin
                starts_cnt++;
                cnt = UART_CYC;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    have_exp = 1'b0;
                    $display("FAIL unexpected byte: got 0x%0h, expected no byte (cycle %0d)", tx_data, cyc);
                end else begin
                    mon_e    = exp_q.pop_front();
                    cur_exp  = mon_e.data;
                    have_exp = 1'b1;
                    check("tx byte", tx_data, mon_e.data);
                    check_range("gap before tx_start",
                                cyc - ((last_done > rst_ref) ? last_done : rst_ref),
                                mon_e.gmin, mon_e.gmax);
                end
            end
        end
        if (byte_rd) byte_data = mem[byte_idx];
    end

    task automatic pulse_req(input logic [7:0] len);
        send_req = 1'b1;
        send_len = len;
        @(negedge clk);
        send_req = 1'b0;
    endtask

    // fr holds 6 payload bytes then CRC low, CRC high, MSB first.
    task automatic start_frame(input logic [63:0] fr);
        for (int i = 0; i < 6; i++) mem[i] = fr[63-8*i -: 8];
        for (int i = 0; i < FRAME_BYTES; i++) begin
            if (i == 0)     exp_q.push_back('{fr[63 -: 8], T35, T35 + 5});
            else if (i < 6) exp_q.push_back('{fr[63-8*i -: 8], 2, 2});
            else            exp_q.push_back('{fr[63-8*i -: 8], 1, 1});
        end
        pulse_req(8'd6);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        check("send_done count", done_cnt, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " tx_start"}, tx_start, 0);
        check({tag, " tx_data"}, tx_data, 0);
        check({tag, " byte_rd"}, byte_rd, 0);
        check({tag, " byte_idx"}, byte_idx, 0);
        check({tag, " send_done"}, send_done, 0);
    endtask

    localparam logic [63:0] FRAME_A = 64'h01_03_00_00_00_0A_C5_CD;
    localparam logic [63:0] FRAME_B = 64'h01_03_00_01_00_01_D5_CA;
    localparam logic [63:0] FRAME_C = 64'h11_03_00_6B_00_03_76_87;

    initial begin
        int s0;
        int n;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // First frame after reset must wait out the full silence.
        repeat (10) @(negedge clk);
        start_frame(FRAME_A);
        wait_done(1);

        // Back-to-back frame; a request while busy must be ignored.
        @(negedge clk);
        start_frame(FRAME_B);
        repeat (T35 + 30) @(negedge clk);
        check("busy mid-frame", busy, 1);
        pulse_req(8'd3);
        wait_done(2);

        // Zero-length request is ignored.
        @(negedge clk);
        pulse_req(8'd0);
        check("busy after len=0 request", busy, 0);
        start_frame(FRAME_C);
        wait_done(3);

        // Reset during the third byte aborts the frame.
        @(negedge clk);
        s0 = starts_cnt;
        start_frame(FRAME_A);
        n = 0;
        while (starts_cnt < s0 + 3 && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        check("third byte reached before abort", starts_cnt >= s0 + 3, 1);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;

        start_frame(FRAME_B);
        wait_done(4);

        repeat (50) @(negedge clk);
        check("final send_done count", done_cnt, 4);
        check("leftover expected bytes", exp_q.size(), 0);
        check("busy at end", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
